// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor, DIGIT bits per cycle over WIDTH/DIGIT cycles.
// Ports: clk, rst (async, active-high); start/mode/a/b are sampled in IDLE (mode 0 = a+b, 1 = a-b);
// busy is high outside IDLE; done pulses for one cycle with sum/cout/ovf valid, which stay held until the next start.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] op_a, op_b;
    logic carry;
    logic [CW-1:0] cnt;
    logic [DIGIT:0] dsum;
    logic msb_c;
    logic last;
    logic [WIDTH+DIGIT-1:0] shifted;
    always_comb begin
        dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // carry into the digit's top bit, recovered from its sum and operand bits
        msb_c = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
        last = cnt == CW'(N - 1);
        shifted = {dsum[DIGIT-1:0], sum};
        state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a <= '0;
            op_b <= '0;
            carry <= 1'b0;
            cnt <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                op_a <= a;
                op_b <= b ^ {WIDTH{mode}};
                carry <= mode;
                cnt <= '0;
            end else if (state == RUN) begin
                op_a <= op_a >> DIGIT;
                op_b <= op_b >> DIGIT;
                carry <= dsum[DIGIT];
                cnt <= cnt + 1'b1;
                sum <= shifted[WIDTH+DIGIT-1:DIGIT];
                if (last) begin
                    cout <= dsum[DIGIT];
                    ovf <= msb_c ^ dsum[DIGIT];
                end
            end
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub across six (WIDTH, DIGIT) instances sharing one stimulus bus.
module tb_serial_add_sub;
    function automatic int wof(int i);
        return i == 0 ? 8 : i == 1 ? 8 : i == 2 ? 16 : i == 3 ? 8 : i == 4 ? 16 : 32;
    endfunction
    function automatic int dof(int i);
        return i == 0 ? 1 : i == 1 ? 4 : i == 2 ? 8 : i == 3 ? 2 : i == 4 ? 4 : 8;
    endfunction
    logic clk = 1'b0;
    logic rst, start, mode;
    logic [31:0] a, b;
    logic busy_o [6];
    logic done_o [6];
    logic cout_o [6];
    logic ovf_o [6];
    logic [31:0] sum_o [6];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 6; g++) begin : u
        localparam int W = wof(g);
        localparam int D = dof(g);
        logic [W-1:0] s;
        serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode),
            .a(a[W-1:0]), .b(b[W-1:0]),
            .busy(busy_o[g]), .done(done_o[g]), .sum(s), .cout(cout_o[g]), .ovf(ovf_o[g])
        );
        assign sum_o[g] = 32'(s);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // reference: {ovf, cout, sum} from plain wide arithmetic and operand/result signs
    function automatic logic [33:0] ref_op(int w, logic m, logic [31:0] x, logic [31:0] y);
        logic [63:0] mask, xx, yy, f, s;
        mask = (64'd1 << w) - 64'd1;
        xx = {32'd0, x} & mask;
        yy = (m ? ~{32'd0, y} : {32'd0, y}) & mask;
        f = xx + yy + {63'd0, m};
        s = f & mask;
        return {(xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]), f[w], s[31:0]};
    endfunction
    task automatic op(input logic m, input logic [31:0] x, input logic [31:0] y, input bit poke);
        logic [33:0] e [6];
        int n;
        for (int i = 0; i < 6; i++) e[i] = ref_op(wof(i), m, x, y);
        start = 1'b1; mode = m; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom; mode = 1'($urandom);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                n = wof(i) / dof(i);
                check($sformatf("busy[%0d] k=%0d", i, k), busy_o[i], k <= n + 1);
                check($sformatf("done[%0d] k=%0d", i, k), done_o[i], k == n + 1);
                if (k >= n + 1) begin
                    check($sformatf("sum[%0d] k=%0d", i, k), sum_o[i], e[i][31:0]);
                    check($sformatf("cout[%0d] k=%0d", i, k), cout_o[i], e[i][32]);
                    check($sformatf("ovf[%0d] k=%0d", i, k), ovf_o[i], e[i][33]);
                end
            end
            start = poke && (k == 2 || k == 3);
            if (start) begin a = ~x; b = x; mode = ~m; end
        end
        start = 1'b0;
    endtask
    task automatic dir(input int i, input logic m, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] es, input logic ec, input logic eo, input bit poke);
        op(m, x, y, poke);
        check($sformatf("dir_sum[%0d]", i), sum_o[i], es);
        check($sformatf("dir_cout[%0d]", i), cout_o[i], ec);
        check($sformatf("dir_ovf[%0d]", i), ovf_o[i], eo);
    endtask
    task automatic held(input logic [31:0] x, input logic [31:0] y);
        int last [6];
        int cnt [6];
        int n;
        logic [33:0] e [6];
        for (int i = 0; i < 6; i++) begin
            e[i] = ref_op(wof(i), 1'b0, x, y);
            last[i] = -1;
            cnt[i] = 0;
        end
        start = 1'b1; mode = 1'b0; a = x; b = y;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (done_o[i]) begin
                    n = wof(i) / dof(i);
                    check($sformatf("held_sum[%0d]", i), sum_o[i], e[i][31:0]);
                    if (last[i] >= 0) check($sformatf("held_gap[%0d]", i), c - last[i], n + 2);
                    last[i] = c;
                    cnt[i]++;
                end
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("held_ops[%0d]", i), cnt[i] >= 3, 1);
            check($sformatf("held_idle[%0d]", i), busy_o[i], 0);
        end
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rst_busy[%0d]", i), busy_o[i], 0);
            check($sformatf("rst_done[%0d]", i), done_o[i], 0);
            check($sformatf("rst_sum[%0d]", i), sum_o[i], 0);
            check($sformatf("rst_cout[%0d]", i), cout_o[i], 0);
            check($sformatf("rst_ovf[%0d]", i), ovf_o[i], 0);
        end
        rst = 1'b0;
        dir(0, 1'b0, 32'h0000007F, 32'h00000001, 32'h80, 1'b0, 1'b1, 1'b0);
        dir(0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00, 1'b1, 1'b0, 1'b0);
        dir(0, 1'b1, 32'h00000005, 32'h00000007, 32'hFE, 1'b0, 1'b0, 1'b0);
        dir(0, 1'b1, 32'h00000080, 32'h00000001, 32'h7F, 1'b1, 1'b1, 1'b0);
        dir(1, 1'b0, 32'h0000003C, 32'h0000000B, 32'h47, 1'b0, 1'b0, 1'b0);
        dir(2, 1'b1, 32'h00001234, 32'h00001234, 32'h0000, 1'b1, 1'b0, 1'b0);
        dir(5, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
        dir(0, 1'b0, 32'h0000007F, 32'h00000001, 32'h80, 1'b0, 1'b1, 1'b1);
        dir(5, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
        held(32'h89ABCDEF, 32'h13579BDF);
        start = 1'b1; mode = 1'b0; a = 32'h55; b = 32'h33;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("arst_busy[%0d]", i), busy_o[i], 0);
            check($sformatf("arst_done[%0d]", i), done_o[i], 0);
            check($sformatf("arst_sum[%0d]", i), sum_o[i], 0);
            check($sformatf("arst_cout[%0d]", i), cout_o[i], 0);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) check($sformatf("arst_nodone[%0d]", i), done_o[i], 0);
        rst = 1'b0;
        dir(0, 1'b0, 32'h00000055, 32'h00000033, 32'h88, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 1000; r++) op(1'($urandom), $urandom, $urandom, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
